signed_div_16by8: RTL and testbench
===================================

SIGNED_DIV_16BY8 -- requirements
Module: signed_div_16by8

Interface
REQ-001 The block SHALL have these parameters: none; all widths are fixed at 16-bit dividend, 8-bit divisor.
REQ-002 The block SHALL have these ports, one per line:
- clk  input  1  sole clock, rising-edge active
- rst  input  1  asynchronous, active-low reset
- startOperation  input  1  request to start a division, sampled in IDLE only
- dividend  input  16  signed two's-complement dividend
- divisor  input  8  signed two's-complement divisor
- quotient  output  16  signed quotient, truncated toward zero
- remainder  output  8  signed remainder; its sign follows the dividend
- done  output  1  one-cycle pulse when results are valid
- busy  output  1  high from the accepting edge until the done pulse
- div_by_zero  output  1  divisor was 0 for the last operation
- overflow  output  1  last operation was -32768 / -1

Function
REQ-003 The block SHALL use states IDLE, SETUP, DIVIDE and FINISH.
REQ-004 In IDLE, when startOperation=1 at a rising edge (edge 0), the block SHALL capture dividend and divisor, set busy=1 and go to SETUP. Operands SHALL NOT be sampled at any other time.
REQ-005 SETUP SHALL store the 16-bit |dividend| and the 9-bit |divisor|; a 9-bit magnitude is required so that divisor=-128 gives 128. SETUP SHALL also record the quotient sign (dividend[15]^divisor[7]) and the remainder sign (dividend[15]).
REQ-006 SETUP SHALL go to FINISH if divisor==0; otherwise it SHALL clear the iteration counter and go to DIVIDE.
REQ-007 DIVIDE SHALL perform one restoring shift-subtract step per cycle, MSB first, for exactly 16 cycles (edges 2..17), then go to FINISH.
REQ-008 FINISH SHALL apply the signs, register quotient, remainder and the flags, pulse done=1 for exactly one cycle, clear busy, and return to IDLE.
REQ-009 Latency SHALL be as follows: done high in the cycle after edge 18 for a nonzero divisor, and in the cycle after edge 2 for divisor==0.
REQ-010 The results SHALL satisfy dividend = quotient*divisor + remainder, with |remainder| < |divisor| and remainder 0 or of the same sign as the dividend.
REQ-011 For divisor==0, FINISH SHALL produce quotient=0, remainder=0, div_by_zero=1 and overflow=0.
REQ-012 For dividend=-32768 and divisor=-1, FINISH SHALL produce quotient=16'h7FFF (saturated), remainder=0 and overflow=1.
REQ-013 Outputs SHALL hold their last values until the next FINISH overwrites them; flags SHALL be cleared on every normal completion.
REQ-014 While busy=1, startOperation SHALL be ignored and SHALL NOT be queued.
REQ-015 If startOperation is held high, a new operation SHALL start on the first edge the block is back in IDLE, i.e. the edge after the done cycle begins.

Reset
REQ-016 rst=0 SHALL immediately force state=IDLE and quotient=0, remainder=0, done=0, busy=0, div_by_zero=0, overflow=0, and clear all internal registers, regardless of the clock.
REQ-017 A reset during SETUP, DIVIDE or FINISH SHALL abort the operation with no done pulse.
REQ-018 After rst returns to 1, the first start SHALL be accepted on the next rising edge.

Verification
REQ-019 Case 1: 375 / 15 -> quotient=25 (16'h0019), remainder=0, done at edge 18, busy high for edges 0..18 exactly.
REQ-020 Case 2: -200 / 7 -> quotient=-28 (16'hFFE4), remainder=-4 (8'hFC).
REQ-021 Case 3: 100 / -3 -> quotient=-33 (16'hFFDF), remainder=1. Also 1000 / -128 -> quotient=-7 (16'hFFF9), remainder=104 (8'h68).
REQ-022 Case 4 (divide by zero): 1234 / 0 -> done at edge 2, div_by_zero=1, quotient=0, remainder=0. A following 375 / 15 SHALL clear div_by_zero.
REQ-023 Case 5 (overflow): -32768 / -1 -> overflow=1, quotient=16'h7FFF, remainder=0. Also -32768 / 1 -> quotient=16'h8000, overflow=0.
REQ-024 Case 6 (robustness): pulse startOperation again at edge 5 with different operands -> ignored, and Case 1 results remain unchanged. Drive rst=0 at edge 9 -> all outputs 0 and no done pulse; a following 375 / 15 completes correctly.

Source files
------------

// File: rtl/signed_div_16by8_if.sv
// Request/result bundle for the 16-by-8 signed divider.
// master drives operands, slave returns results and status.
interface signed_div_16by8_if;
  logic        startOperation;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        done;
  logic        busy;
  logic        div_by_zero;
  logic        overflow;

  modport master (
    output startOperation, dividend, divisor,
    input  quotient, remainder, done, busy,
    input  div_by_zero, overflow
  );

  modport slave (
    input  startOperation, dividend, divisor,
    output quotient, remainder, done, busy,
    output div_by_zero, overflow
  );
endinterface

// File: rtl/signed_div_16by8.sv
// Multi-cycle signed 16/8 divider, restoring algorithm on magnitudes.
// Quotient truncates toward zero; remainder takes the dividend's sign.
module signed_div_16by8 (
  input logic               clk,
  input logic               rst,
  signed_div_16by8_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DIVIDE,
    FINISH
  } state_t;

  state_t state, state_nx;

  logic [15:0] a_q;
  logic [7:0]  b_q;
  logic [15:0] q_r;
  logic [7:0]  r_r;
  logic [8:0]  d_r;
  logic [3:0]  cnt;
  logic        qsgn;
  logic        rsgn;

  logic [15:0] a_mag;
  logic [8:0]  b_ext;
  logic [8:0]  d_mag;
  logic [8:0]  r_sh;
  logic        ge;
  logic [7:0]  r_nx;
  logic        dz;
  logic        sat;
  logic [15:0] q_fin;
  logic [7:0]  r_fin;

  assign a_mag = a_q[15] ? -a_q : a_q;
  // 9 bits so that -128 yields +128
  assign b_ext = {b_q[7], b_q};
  assign d_mag = b_q[7] ? -b_ext : b_ext;

  assign r_sh = {r_r, q_r[15]};
  assign ge   = r_sh >= d_r;
  assign r_nx = ge ? 8'(r_sh - d_r) : r_sh[7:0];

  assign dz  = b_q == 8'd0;
  assign sat = (a_q == 16'h8000) && (b_q == 8'hFF);

  always_comb begin
    q_fin = qsgn ? -q_r : q_r;
    r_fin = rsgn ? -r_r : r_r;
    unique case (1'b1)
      dz: begin
        q_fin = '0;
        r_fin = '0;
      end
      sat: begin
        q_fin = 16'h7FFF;
        r_fin = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (bus.startOperation)
          state_nx = SETUP;
      SETUP:
        state_nx = dz ? FINISH : DIVIDE;
      DIVIDE:
        if (cnt == 4'd15)
          state_nx = FINISH;
      FINISH:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q             <= '0;
      b_q             <= '0;
      q_r             <= '0;
      r_r             <= '0;
      d_r             <= '0;
      cnt             <= '0;
      qsgn            <= 1'b0;
      rsgn            <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.done        <= 1'b0;
      bus.busy        <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE:
          if (bus.startOperation) begin
            a_q      <= bus.dividend;
            b_q      <= bus.divisor;
            bus.busy <= 1'b1;
          end
        SETUP: begin
          q_r  <= a_mag;
          r_r  <= '0;
          d_r  <= d_mag;
          qsgn <= a_q[15] ^ b_q[7];
          rsgn <= a_q[15];
          cnt  <= '0;
        end
        DIVIDE: begin
          q_r <= {q_r[14:0], ge};
          r_r <= r_nx;
          cnt <= cnt + 4'd1;
        end
        FINISH: begin
          bus.quotient    <= q_fin;
          bus.remainder   <= r_fin;
          bus.div_by_zero <= dz;
          bus.overflow    <= sat;
          bus.done        <= 1'b1;
          bus.busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_div_16by8.sv
// Scoreboard bench for signed_div_16by8: reference results from
// native signed / and %, checked with latency when done pulses.
module tb_signed_div_16by8;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    logic        ov;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];

  signed_div_16by8_if bus();

  signed_div_16by8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h @cyc %0d",
               tag, got, want, cyc);
    end
  endtask

  function automatic exp_t model(input logic signed [15:0] a,
                                 input logic signed [7:0] b,
                                 input int acc);
    exp_t m;
    int ia;
    int ib;
    ia    = a;
    ib    = b;
    m.acc = acc;
    m.dz  = 1'b0;
    m.ov  = 1'b0;
    m.lat = 18;
    if (ib == 0) begin
      m.q   = '0;
      m.r   = '0;
      m.dz  = 1'b1;
      m.lat = 2;
    end else if (ia == -32768 && ib == -1) begin
      m.q  = 16'h7FFF;
      m.r  = '0;
      m.ov = 1'b1;
    end else begin
      m.q = 16'(ia / ib);
      m.r = 8'(ia % ib);
    end
    return m;
  endfunction

  always @(negedge clk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", 32'(bus.quotient), 32'(e.q));
        chk("remainder", 32'(bus.remainder), 32'(e.r));
        chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dz));
        chk("overflow", 32'(bus.overflow), 32'(e.ov));
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
        chk("busy_at_done", 32'(bus.busy), 32'd0);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 40 && sb.size() != 0; i++)
      @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      chk("timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic signed [15:0] a,
                        input logic signed [7:0] b);
    bus.dividend       = a;
    bus.divisor        = b;
    bus.startOperation = 1'b1;
    @(posedge clk);
    #1;
    bus.startOperation = 1'b0;
    sb.push_back(model(a, b, cyc));
    chk("busy_accept", 32'(bus.busy), 32'd1);
    wait_idle();
  endtask

  initial begin
    int acc;
    checks             = 0;
    failures           = 0;
    bus.startOperation = 1'b0;
    bus.dividend       = '0;
    bus.divisor        = '0;
    rst                = 1'b1;
    #2 rst = 1'b0;
    #3;
    chk("rst_quotient", 32'(bus.quotient), 32'd0);
    chk("rst_remainder", 32'(bus.remainder), 32'd0);
    chk("rst_flags", {28'd0, bus.done, bus.busy,
                      bus.div_by_zero, bus.overflow}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // held start: two back-to-back ops, second samples new operands
    bus.dividend       = 16'sd375;
    bus.divisor        = 8'sd15;
    bus.startOperation = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    sb.push_back(model(16'sd375, 8'sd15, acc));
    bus.dividend = -16'sd200;
    bus.divisor  = 8'sd7;
    repeat (17) @(posedge clk);
    #1;
    chk("busy_edge17", 32'(bus.busy), 32'd1);
    chk("done_edge17", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;
    chk("busy_edge18", 32'(bus.busy), 32'd0);
    chk("done_edge18", 32'(bus.done), 32'd1);
    @(posedge clk);
    #1;
    chk("reaccept_busy", 32'(bus.busy), 32'd1);
    chk("done_width", 32'(bus.done), 32'd0);
    bus.startOperation = 1'b0;
    sb.push_back(model(-16'sd200, 8'sd7, cyc));
    wait_idle();

    run_op(16'sd100, -8'sd3);
    run_op(16'sd1000, -8'sd128);
    run_op(16'sd1234, 8'sd0);
    run_op(16'sd375, 8'sd15);
    run_op(-16'sd32768, -8'sd1);
    run_op(-16'sd32768, 8'sd1);
    run_op(16'sd32767, -8'sd128);
    run_op(-16'sd32768, -8'sd128);
    run_op(-16'sd1, 8'sd127);
    run_op(16'sd0, -8'sd5);
    run_op(-16'sd129, 8'sd0);

    for (int i = 0; i < 12; i++)
      run_op(16'($urandom), 8'($urandom));

    // late start request while busy must be dropped
    bus.dividend       = 16'sd375;
    bus.divisor        = 8'sd15;
    bus.startOperation = 1'b1;
    @(posedge clk);
    #1;
    bus.startOperation = 1'b0;
    sb.push_back(model(16'sd375, 8'sd15, cyc));
    repeat (4) @(posedge clk);
    #1;
    bus.dividend       = -16'sd1000;
    bus.divisor        = 8'sd3;
    bus.startOperation = 1'b1;
    @(posedge clk);
    #1;
    bus.startOperation = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    chk("not_queued", 32'(bus.busy), 32'd0);

    // reset in the middle of DIVIDE
    bus.dividend       = 16'sd375;
    bus.divisor        = 8'sd15;
    bus.startOperation = 1'b1;
    @(posedge clk);
    #1;
    bus.startOperation = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_quotient", 32'(bus.quotient), 32'd0);
    chk("abort_remainder", 32'(bus.remainder), 32'd0);
    chk("abort_flags", {28'd0, bus.done, bus.busy,
                        bus.div_by_zero, bus.overflow}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_idle", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    run_op(16'sd375, 8'sd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
